ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Downstream consumer of the packed control bundles produced in ID: WB {RegWrite,MemtoReg}, M {MemRead,MemWrite}, EX {ALUSrc,ALUOp[1:0],RegDst}.
- Registers these bundles through the ID/EX, EX/MEM and MEM/WB pipeline stages and unpacks them into per-stage control signals.
- Carries the destination register number with the control and exports the per-stage RegWrite/MemRead/destination information that the hazard and forwarding units consume.
- Supports a global freeze for multi-cycle memory, a synchronous ID/EX flush, and a saturating bubble counter.

Parameters:
REG_W, 5, register-number width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
WB_i  in  2  {RegWrite, MemtoReg} from ID
M_i  in  2  {MemRead, MemWrite} from ID
EX_i  in  4  {ALUSrc, ALUOp[1:0], RegDst} from ID
valid_i  in  1  1 = real instruction in ID; 0 = bubble
rt_i  in  REG_W  rt field of the ID instruction
rd_i  in  REG_W  rd field of the ID instruction
mem_stall_i  in  1  freeze all three stage registers
ex_flush_i  in  1  load a bubble into ID/EX
ex_ALUSrc_o  out  1  EX-stage ALUSrc
ex_ALUOp_o  out  2  EX-stage ALUOp
ex_RegDst_o  out  1  EX-stage RegDst
ex_MemRead_o  out  1  EX-stage MemRead (load-use detection)
ex_wr_reg_o  out  REG_W  EX destination: RegDst ? rd : rt
mem_MemRead_o  out  1  MEM-stage MemRead
mem_MemWrite_o  out  1  MEM-stage MemWrite
mem_RegWrite_o  out  1  MEM-stage qualified RegWrite
mem_wr_reg_o  out  REG_W  MEM-stage destination
wb_RegWrite_o  out  1  WB-stage qualified RegWrite
wb_MemtoReg_o  out  1  WB-stage MemtoReg
wb_wr_reg_o  out  REG_W  WB-stage destination
bubble_cnt_o  out  CNT_W  saturating count of bubbles captured into ID/EX

Behaviour:
- Reset: rst_i low asynchronously clears every stage register, every valid bit and bubble_cnt_o to 0. All outputs read 0 while rst_i is low and until the first capture after release.
- Stage registers:
  - ID/EX holds WB, M, EX, rt, rd, valid.
  - EX/MEM holds WB, M, wr_reg, valid.
  - MEM/WB holds WB, wr_reg, valid.
- Advance (mem_stall_i=0) on each rising edge:
  - ID/EX <= inputs.
  - EX/MEM <= ID/EX (wr_reg = RegDst ? rd : rt, resolved at this transfer).
  - MEM/WB <= EX/MEM.
- Latency: a bundle presented at edge N appears on ex_* after edge N, on mem_* after N+1, and on wb_* after N+2.
- ex_wr_reg_o is combinational from the ID/EX contents.
- Bubble: valid_i=0 forces the captured WB, M and EX bundles to 0 regardless of the input values.
- Flush: ex_flush_i=1 with mem_stall_i=0 loads all-zero into ID/EX (valid=0). The downstream stages still advance normally.
- Freeze: mem_stall_i=1 holds all three stages and bubble_cnt_o unchanged.
  - mem_stall_i has priority over ex_flush_i; a flush during a freeze is dropped, and the upstream unit holds ex_flush_i until the freeze ends.
- $0 qualification: mem_RegWrite_o = stored RegWrite && mem_wr_reg_o != 0. wb_RegWrite_o uses the same rule. The stored bit is kept; only the output is masked.
- Bubble counter: increments by 1 on every advancing edge where the ID/EX capture is a bubble (valid_i=0 or ex_flush_i=1). It saturates at 2^CNT_W-1 with no wrap.
- Outputs are pure functions of the stage registers. There are no combinational paths from the *_i inputs to any output.

Test Plan:
- Reset: drive random inputs with rst_i=0, then release → all outputs 0. Then WB_i=10, M_i=00, EX_i=0001, rt=3, rd=8, valid=1 → after 1 edge ex_RegDst_o=1, ex_wr_reg_o=8; after 2 edges mem_RegWrite_o=1, mem_wr_reg_o=8; after 3 edges wb_RegWrite_o=1, wb_wr_reg_o=8.
- Load followed by freeze: load bundle WB=11, M=10, EX=1000, rt=5 → ex_MemRead_o=1, ex_wr_reg_o=5. Assert mem_stall_i for 3 cycles during MEM → mem_MemRead_o stays 1 and wb_* is unchanged for 3 cycles, then advances.
- Bubble and flush: valid_i=0 with WB_i=11, M_i=11 → ID/EX captures zeros and bubble_cnt_o=1. Next, ex_flush_i=1 with valid_i=1 → zeros captured and bubble_cnt_o=2.
- Flush under freeze: ex_flush_i=1 and mem_stall_i=1 together → no state change, bubble_cnt_o unchanged.
- $0 destination: WB=10, EX=0001, rd=0 → mem_RegWrite_o=0 and wb_RegWrite_o=0, while mem_wr_reg_o=0 still propagates.
- Saturation and mid-run reset: CNT_W=2, 5 consecutive bubbles → bubble_cnt_o=3. Assert rst_i=0 mid-cycle with a store in MEM → mem_MemWrite_o drops to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Control-bundle bus between the ID stage and the ctrl_pipe stage registers.
// The slave side is the pipe itself; the master side is the ID/hazard logic.
interface ctrl_pipe_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [1:0]       WB_i;
  logic [1:0]       M_i;
  logic [3:0]       EX_i;
  logic             valid_i;
  logic [REG_W-1:0] rt_i;
  logic [REG_W-1:0] rd_i;
  logic             mem_stall_i;
  logic             ex_flush_i;

  logic             ex_ALUSrc_o;
  logic [1:0]       ex_ALUOp_o;
  logic             ex_RegDst_o;
  logic             ex_MemRead_o;
  logic [REG_W-1:0] ex_wr_reg_o;
  logic             mem_MemRead_o;
  logic             mem_MemWrite_o;
  logic             mem_RegWrite_o;
  logic [REG_W-1:0] mem_wr_reg_o;
  logic             wb_RegWrite_o;
  logic             wb_MemtoReg_o;
  logic [REG_W-1:0] wb_wr_reg_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport slave (
    input  WB_i, M_i, EX_i, valid_i, rt_i, rd_i, mem_stall_i, ex_flush_i,
    output ex_ALUSrc_o, ex_ALUOp_o, ex_RegDst_o, ex_MemRead_o, ex_wr_reg_o,
           mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o, mem_wr_reg_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_wr_reg_o, bubble_cnt_o
  );

  modport master (
    output WB_i, M_i, EX_i, valid_i, rt_i, rd_i, mem_stall_i, ex_flush_i,
    input  ex_ALUSrc_o, ex_ALUOp_o, ex_RegDst_o, ex_MemRead_o, ex_wr_reg_o,
           mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o, mem_wr_reg_o,
           wb_RegWrite_o, wb_MemtoReg_o, wb_wr_reg_o, bubble_cnt_o
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX -> EX/MEM -> MEM/WB control pipeline with freeze, ID/EX flush,
// $0-qualified RegWrite exports and a saturating bubble counter.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ctrl_pipe_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             w_advance;
  logic             w_bubble;
  logic [REG_W-1:0] w_ex_wr_reg_p0;

  logic [1:0]       r_wb_p0;
  logic [1:0]       r_m_p0;
  logic [3:0]       r_ex_p0;
  logic [REG_W-1:0] r_rt_p0;
  logic [REG_W-1:0] r_rd_p0;
  logic             r_vld_p0;

  logic [1:0]       r_wb_p1;
  logic [1:0]       r_m_p1;
  logic [REG_W-1:0] r_wr_reg_p1;
  logic             r_vld_p1;

  logic [1:0]       r_wb_p2;
  logic [REG_W-1:0] r_wr_reg_p2;
  logic             r_vld_p2;

  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_advance = !bus.mem_stall_i;
  assign w_bubble  = bus.ex_flush_i || !bus.valid_i;

  // ID/EX: a flush clears everything; a plain bubble clears only the bundles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_p0  <= '0;
      r_m_p0   <= '0;
      r_ex_p0  <= '0;
      r_rt_p0  <= '0;
      r_rd_p0  <= '0;
      r_vld_p0 <= 1'b0;
    end else if (w_advance) begin
      if (bus.ex_flush_i) begin
        r_wb_p0  <= '0;
        r_m_p0   <= '0;
        r_ex_p0  <= '0;
        r_rt_p0  <= '0;
        r_rd_p0  <= '0;
        r_vld_p0 <= 1'b0;
      end else begin
        r_wb_p0  <= bus.valid_i ? bus.WB_i : 2'b00;
        r_m_p0   <= bus.valid_i ? bus.M_i  : 2'b00;
        r_ex_p0  <= bus.valid_i ? bus.EX_i : 4'b0000;
        r_rt_p0  <= bus.rt_i;
        r_rd_p0  <= bus.rd_i;
        r_vld_p0 <= bus.valid_i;
      end
    end
  end

  assign w_ex_wr_reg_p0 = r_ex_p0[0] ? r_rd_p0 : r_rt_p0;

  // EX/MEM: destination register resolved here so later stages carry one field
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_p1     <= '0;
      r_m_p1      <= '0;
      r_wr_reg_p1 <= '0;
      r_vld_p1    <= 1'b0;
    end else if (w_advance) begin
      r_wb_p1     <= r_wb_p0;
      r_m_p1      <= r_m_p0;
      r_wr_reg_p1 <= w_ex_wr_reg_p0;
      r_vld_p1    <= r_vld_p0;
    end
  end

  // MEM/WB
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_p2     <= '0;
      r_wr_reg_p2 <= '0;
      r_vld_p2    <= 1'b0;
    end else if (w_advance) begin
      r_wb_p2     <= r_wb_p1;
      r_wr_reg_p2 <= r_wr_reg_p1;
      r_vld_p2    <= r_vld_p1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_advance && w_bubble) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign bus.ex_ALUSrc_o    = r_ex_p0[3];
  assign bus.ex_ALUOp_o     = r_ex_p0[2:1];
  assign bus.ex_RegDst_o    = r_ex_p0[0];
  assign bus.ex_MemRead_o   = r_m_p0[1];
  assign bus.ex_wr_reg_o    = w_ex_wr_reg_p0;

  // Writes to $0 are masked at the output so hazard/forwarding never match on $0
  assign bus.mem_MemRead_o  = r_m_p1[1];
  assign bus.mem_MemWrite_o = r_m_p1[0];
  assign bus.mem_RegWrite_o = r_vld_p1 && r_wb_p1[1] && (r_wr_reg_p1 != '0);
  assign bus.mem_wr_reg_o   = r_wr_reg_p1;

  assign bus.wb_RegWrite_o  = r_vld_p2 && r_wb_p2[1] && (r_wr_reg_p2 != '0);
  assign bus.wb_MemtoReg_o  = r_wb_p2[0];
  assign bus.wb_wr_reg_o    = r_wr_reg_p2;

  assign bus.bubble_cnt_o   = r_bubble_cnt;

endmodule
